assoc_cache: RTL and testbench

- Parametrised N-way set-associative cache: successor to the team's direct-mapped write-through/no-write-allocate cache.
- Adds configurable associativity, round-robin replacement, and a multi-word line-refill FSM with a req/ack memory handshake.
- Sits between a CPU load/store port and a word-addressed backing memory.
- Keeps the write-through, no-write-allocate policy.

---
 rtl/assoc_cache_if.sv | 38 +++
 rtl/assoc_cache.sv | 203 ++++++++++++++++++++
 tb/tb_assoc_cache.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : assoc_cache_if
// Description : CPU load/store port and backing-memory word port of the
//               set-associative cache, bundled as one interface.
//               slave  = cache side, master = CPU/memory environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface assoc_cache_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  // CPU side
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_cache
// Description : N-way set-associative, write-through / no-write-allocate
//               cache with round-robin replacement and a multi-word line
//               refill over a req/ack word memory port.
//               Optional macro CACHE_STATS_EN adds saturating read hit/miss
//               counters (hit_count / miss_count ports).
//               All LOG_* parameters are expected to be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_cache #(
  parameter int LOG_NUM_SETS   = 2,
  parameter int LOG_NUM_WAYS   = 1,
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int STAT_WIDTH     = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active low
  assoc_cache_if.slave      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  localparam int NUM_SETS   = 1 << LOG_NUM_SETS;
  localparam int NUM_WAYS   = 1 << LOG_NUM_WAYS;
  localparam int NUM_BLOCKS = 1 << LOG_NUM_BLOCKS;
  localparam int TAG_W      = ADDR_WIDTH - LOG_NUM_SETS - LOG_NUM_BLOCKS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;

  // Address fields: {tag, index, offset}
  logic [TAG_W-1:0]          req_tag;
  logic [LOG_NUM_SETS-1:0]   req_idx;
  logic [LOG_NUM_BLOCKS-1:0] req_off;

  assign req_tag = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = bus.cpu_addr[LOG_NUM_BLOCKS +: LOG_NUM_SETS];
  assign req_off = bus.cpu_addr[LOG_NUM_BLOCKS-1:0];

  // Storage: data and tags carry no reset, only valid bits qualify them
  logic [DATA_WIDTH-1:0] data_arr [NUM_WAYS][NUM_SETS][NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_arr  [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]     valid;
  logic [NUM_SETS-1:0][LOG_NUM_WAYS-1:0] rr;

  logic [LOG_NUM_WAYS-1:0]   victim;     // way being refilled
  logic [LOG_NUM_BLOCKS-1:0] cnt;        // refill word counter
  logic [NUM_WAYS-1:0]       hit_vec;
  logic [LOG_NUM_WAYS-1:0]   hit_way;
  logic [LOG_NUM_WAYS-1:0]   alloc_way;
  logic                      hit;
  logic                      all_valid;
  logic                      read_hit;
  logic                      read_miss;
  logic                      write_go;
  logic                      refill_ack;
  logic                      last_word;

  // Parallel tag compare across every way of the addressed set
  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      assign hit_vec[w] = valid[req_idx][w] && (tag_arr[w][req_idx] == req_tag);
    end
  endgenerate

  assign hit        = |hit_vec;
  assign all_valid  = &valid[req_idx];
  assign read_hit   = (state == ST_IDLE) && bus.cpu_req && !bus.cpu_we && hit;
  assign read_miss  = (state == ST_IDLE) && bus.cpu_req && !bus.cpu_we && !hit;
  assign write_go   = (state == ST_IDLE) && bus.cpu_req && bus.cpu_we;
  assign refill_ack = (state == ST_REFILL) && bus.mem_ack;
  assign last_word  = (cnt == LOG_NUM_BLOCKS'(NUM_BLOCKS - 1));

  // Encode the (at most one) hitting way
  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = LOG_NUM_WAYS'(w);
    end
  end

  // Pick the refill victim: lowest invalid way, else the set's round-robin way
  always_comb begin
    alloc_way = rr[req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) alloc_way = LOG_NUM_WAYS'(w);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) state_next = ST_WRITE;
          else if (!hit)  state_next = ST_REFILL;
        end
      end
      ST_REFILL: if (bus.mem_ack && last_word) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      ST_WRITE:  if (bus.mem_ack) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode for both the CPU and the memory port
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        bus.cpu_ready = read_hit;
        bus.cpu_rdata = data_arr[hit_way][req_idx][req_off];
      end
      ST_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_idx, cnt};
      end
      ST_RESP: begin
        bus.cpu_ready = 1'b1;
        bus.cpu_rdata = data_arr[victim][req_idx][req_off];
      end
      ST_WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_ready = bus.mem_ack;
      end
      default: ;
    endcase
  end

  // Valid bits, round-robin pointers, victim and refill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      rr     <= '0;
      victim <= '0;
      cnt    <= '0;
    end else begin
      if (read_miss) begin
        victim                    <= alloc_way;
        valid[req_idx][alloc_way] <= 1'b0;
        cnt                       <= '0;
        if (all_valid) rr[req_idx] <= rr[req_idx] + 1'b1;
      end
      if (refill_ack) begin
        cnt <= cnt + 1'b1;
        if (last_word) valid[req_idx][victim] <= 1'b1;
      end
    end
  end

  // Data/tag array writes: refill words, and write-hit updates on IDLE exit
  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_arr[victim][req_idx][cnt] <= bus.mem_rdata;
      if (last_word) tag_arr[victim][req_idx] <= req_tag;
    end
    if (write_go && hit) begin
      data_arr[hit_way][req_idx][req_off] <= bus.cpu_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating read hit / read miss counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
      if (read_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_cache
// Description : Scoreboard bench for assoc_cache. A reference model predicts
//               hit/miss and read data for each request; a monitor compares
//               every cpu_ready and memory transfer against the queued
//               expectation. Random memory ack delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_cache;

  localparam int LOG_NUM_SETS   = 2;
  localparam int LOG_NUM_WAYS   = 1;
  localparam int LOG_NUM_BLOCKS = 1;
  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 8;
  localparam int STAT_WIDTH     = 16;
  localparam int NUM_SETS       = 4;
  localparam int NUM_WAYS       = 2;
  localparam int NUM_BLOCKS     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  assoc_cache_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

`ifdef CACHE_STATS_EN
  logic [STAT_WIDTH-1:0] hit_count;
  logic [STAT_WIDTH-1:0] miss_count;
`endif

  assoc_cache #(
    .LOG_NUM_SETS  (LOG_NUM_SETS),
    .LOG_NUM_WAYS  (LOG_NUM_WAYS),
    .LOG_NUM_BLOCKS(LOG_NUM_BLOCKS),
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .STAT_WIDTH    (STAT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          hit;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;
  bit mon_quiet   = 1'b0;

  // Reference model: architectural memory plus per-set residency
  logic [31:0] ref_mem   [256];
  logic [31:0] mem_array [256];
  bit          m_valid [NUM_SETS][NUM_WAYS];
  int          m_tag   [NUM_SETS][NUM_WAYS];
  int          m_rr    [NUM_SETS];
  int          exp_hits;
  int          exp_misses;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) m_valid[s][w] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Issue one CPU request, predicting its outcome into the scoreboard
  task automatic do_req(bit we, logic [7:0] addr, logic [31:0] data);
    exp_t e;
    int   s_idx = int'(addr[2:1]);
    int   tag   = int'(addr[7:3]);
    int   way   = -1;
    int   n     = 0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (m_valid[s_idx][w] && m_tag[s_idx][w] == tag) way = w;
    e.we   = we;
    e.addr = addr;
    e.hit  = (way >= 0);
    if (we) begin
      e.data        = data;
      ref_mem[addr] = data;
    end else begin
      e.data = ref_mem[addr];
      if (way >= 0) exp_hits++;
      else begin
        int v = -1;
        exp_misses++;
        for (int w = NUM_WAYS - 1; w >= 0; w--) if (!m_valid[s_idx][w]) v = w;
        if (v < 0) begin
          v            = m_rr[s_idx];
          m_rr[s_idx]  = (m_rr[s_idx] + 1) % NUM_WAYS;
        end
        m_valid[s_idx][v] = 1'b1;
        m_tag[s_idx][v]   = tag;
      end
    end
    sb.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = we ? data : $urandom;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ready && n < 200);
    if (!bus.cpu_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: no cpu_ready for addr %h", addr);
      finish_now();
    end
    if (!we && e.hit) check("hit_latency", n, 1);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder: random-latency ack, reads served from mem_array
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && bus.mem_req && $urandom_range(0, 2) == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_we ? $urandom : mem_array[bus.mem_addr];
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Memory write commit at the accepting edge
  always @(negedge clk) begin
    if (rst && bus.mem_req && bus.mem_ack && bus.mem_we)
      mem_array[bus.mem_addr] = bus.mem_wdata;
  end

  // Monitor: compares memory transfers and CPU completions to the scoreboard
  int rd_words = 0;
  int wr_words = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst || mon_quiet) begin
      rd_words = 0;
      wr_words = 0;
    end else begin
      if (bus.mem_req && bus.mem_ack) begin
        if (sb.size() == 0) check("mem_unexpected", 1, 0);
        else if (bus.mem_we) begin
          wr_words++;
          check("mem_waddr", {24'h0, bus.mem_addr}, {24'h0, sb[0].addr});
          check("mem_wdata", bus.mem_wdata, sb[0].data);
        end else begin
          check("refill_addr", {24'h0, bus.mem_addr},
                {24'h0, sb[0].addr[7:1], 1'(rd_words)});
          rd_words++;
        end
      end
      if (bus.cpu_ready) begin
        if (sb.size() == 0) check("ready_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          if (!e.we) begin
            check("rdata", bus.cpu_rdata, e.data);
            check("read_mem_idle", {31'h0, bus.mem_req}, 0);
            check("refill_words", rd_words, e.hit ? 0 : NUM_BLOCKS);
          end else begin
            check("write_ready_with_ack", {31'h0, bus.mem_ack}, 1);
            check("refill_words", rd_words, 0);
          end
          check("write_words", wr_words, e.we ? 1 : 0);
          rd_words = 0;
          wr_words = 0;
        end
      end
    end
  end

  initial begin
    int n;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a]   = 32'(a) + 32'h90;
      mem_array[a] = 32'(a) + 32'h90;
    end
    model_reset();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // Power-on reset
    #3 rst = 1'b0;
    #1;
    check("reset_cpu_ready", {31'h0, bus.cpu_ready}, 0);
    check("reset_mem_req",   {31'h0, bus.mem_req},   0);
    check("reset_mem_we",    {31'h0, bus.mem_we},    0);
`ifdef CACHE_STATS_EN
    check("reset_hit_count",  32'(hit_count),  0);
    check("reset_miss_count", 32'(miss_count), 0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed: refill, hit, write-through, write miss, replacement in set 0
    do_req(1'b0, 8'h10, '0);
    do_req(1'b0, 8'h11, '0);
    do_req(1'b1, 8'h10, 32'h55);
    do_req(1'b0, 8'h10, '0);
    do_req(1'b1, 8'h30, 32'h77);
    do_req(1'b0, 8'h30, '0);
    do_req(1'b0, 8'h31, '0);
    do_req(1'b0, 8'h10, '0);
    do_req(1'b0, 8'h30, '0);
    do_req(1'b0, 8'h50, '0);
    do_req(1'b0, 8'h30, '0);
    do_req(1'b0, 8'h10, '0);
`ifdef CACHE_STATS_EN
    check("hit_count",  32'(hit_count),  exp_hits);
    check("miss_count", 32'(miss_count), exp_misses);
`endif

    // Reset in the middle of a refill
    mon_quiet = 1'b1;
    @(posedge clk);
    #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 8'h60;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req && bus.mem_ack) && n < 200);
    if (!(bus.mem_req && bus.mem_ack)) begin
      vectors++;
      miscompares++;
      $display("FAIL refill_timeout: no first refill ack");
      finish_now();
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_mem_req",   {31'h0, bus.mem_req},   0);
    check("async_cpu_ready", {31'h0, bus.cpu_ready}, 0);
    check("async_mem_we",    {31'h0, bus.mem_we},    0);
`ifdef CACHE_STATS_EN
    check("rst_hit_count",  32'(hit_count),  0);
    check("rst_miss_count", 32'(miss_count), 0);
`endif
    bus.cpu_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    mon_quiet = 1'b0;
    @(posedge clk);
    #1;
    do_req(1'b0, 8'h60, '0);
    do_req(1'b0, 8'h61, '0);

    // Randomised traffic over a small address window to mix hits and misses
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 3) do_req(1'b1, a, $urandom);
      else                          do_req(1'b0, a, '0);
    end

    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 0);
`ifdef CACHE_STATS_EN
    check("final_hit_count",  32'(hit_count),  exp_hits);
    check("final_miss_count", 32'(miss_count), exp_misses);
`endif
    finish_now();
  end

endmodule
`default_nettype wire
